imem_loader: RTL and testbench

- Writer side of the instruction-memory interface: receives a program image as a byte stream and writes it into instruction memory as 32-bit words.
- Holds the processor core in reset while loading; releases it once the image is complete.
- Sits between a byte source (UART receiver or testbench stream) and the instruction memory write port, beside the processor top.

---
 rtl/imem_loader_pkg.sv | 38 +++
 rtl/imem_loader_if.sv | 26 ++
 rtl/imem_word_assembler.sv | 44 ++++
 rtl/imem_loader.sv | 134 +++++++++++++
 tb/tb_imem_loader.sv | 314 +++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/imem_loader_pkg.sv
// Shared types and constants for the instruction-memory loader.
// IMEM_LOADER_CHECKSUM_EN adds the trailing XOR checksum state.
package imem_loader_pkg;

  localparam int HDR_BYTES      = 2;
  localparam int BYTES_PER_WORD = 4;
  localparam int LANE_W         = $clog2(BYTES_PER_WORD);

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_CNT_LO = 3'd1,
    ST_CNT_HI = 3'd2,
    ST_DATA   = 3'd3,
    ST_DONE   = 3'd4,
    ST_ERROR  = 3'd5
`ifdef IMEM_LOADER_CHECKSUM_EN
    ,
    ST_CHK    = 3'd6
`endif
  } state_t;

  // Where the FSM goes once the payload (possibly empty) has been consumed.
`ifdef IMEM_LOADER_CHECKSUM_EN
  localparam state_t ST_AFTER_DATA = ST_CHK;
`else
  localparam state_t ST_AFTER_DATA = ST_DONE;
`endif

  function automatic logic is_busy(input state_t s);
    logic b;
    b = (s == ST_CNT_LO) || (s == ST_CNT_HI) || (s == ST_DATA);
`ifdef IMEM_LOADER_CHECKSUM_EN
    b = b || (s == ST_CHK);
`endif
    return b;
  endfunction

endpackage

// File: rtl/imem_loader_if.sv
// Byte-stream input and instruction-memory write port of the loader.
interface imem_loader_if #(
  parameter int ADDR_W = 6
);

  logic              s_valid;
  logic [7:0]        s_data;
  logic              s_ready;
  logic              mem_we;
  logic [ADDR_W-1:0] mem_addr;
  logic [31:0]       mem_wdata;

  // Stream handshake: a byte moves on a rising clk edge where s_valid && s_ready;
  // s_data must be stable while s_valid is high, and s_valid without s_ready is
  // simply held, never consumed. mem_we is a single-cycle write strobe, no ready.
  modport master (
    input  s_valid, s_data,
    output s_ready, mem_we, mem_addr, mem_wdata
  );

  modport slave (
    output s_valid, s_data,
    input  s_ready, mem_we, mem_addr, mem_wdata
  );

endinterface

// File: rtl/imem_word_assembler.sv
// Packs accepted payload bytes little-endian into 32-bit words and flags the
// byte that completes each word.
module imem_word_assembler
  import imem_loader_pkg::*;
(
  input  logic        clk,
  input  logic        rst_n,
  input  logic        clear_i,
  input  logic        byte_valid_i,
  input  logic [7:0]  byte_i,
  output logic        word_done_o,
  output logic [31:0] word_o
);

  logic [LANE_W-1:0] lane_q, lane_d;
  logic [31:0]       asm_q, asm_d;

  always_comb begin
    lane_d = lane_q;
    asm_d  = asm_q;
    if (clear_i) begin
      lane_d = '0;
      asm_d  = '0;
    end else if (byte_valid_i) begin
      // Lane counter wraps to 0 after the top byte of each word.
      lane_d = lane_q + 1'b1;
      asm_d[{lane_q, 3'b000} +: 8] = byte_i;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      lane_q <= '0;
      asm_q  <= '0;
    end else begin
      lane_q <= lane_d;
      asm_q  <= asm_d;
    end
  end

  assign word_done_o = byte_valid_i && !clear_i && (lane_q == LANE_W'(BYTES_PER_WORD - 1));
  assign word_o      = asm_d;

endmodule

// File: rtl/imem_loader.sv
// Loads a length-prefixed byte image into instruction memory and holds the core
// in reset until it completes. IMEM_LOADER_CHECKSUM_EN enables the XOR check byte.
module imem_loader
  import imem_loader_pkg::*;
#(
  parameter int ADDR_W = 6,
  parameter int CNT_W  = 16
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          start,
  imem_loader_if.master bus,
  output logic          core_rst_n,
  output logic          busy,
  output logic          done,
  output logic          error,
  output state_t        dbg_state
);

  localparam logic [CNT_W-1:0] MAX_WORDS = CNT_W'(2 ** ADDR_W);

  state_t                   state_q, state_d;
  logic [7:0]               cnt_lo_q;
  logic [CNT_W-1:0]         n_q;
  logic [CNT_W-1:0]         idx_q;
  logic                     s_ready_q, mem_we_q, core_rst_n_q;
  logic                     busy_q, done_q, error_q;
  logic [ADDR_W-1:0]        mem_addr_q;
  logic [31:0]              mem_wdata_q;
`ifdef IMEM_LOADER_CHECKSUM_EN
  logic [7:0]               xor_q;
`endif

  logic                     accept, start_ok, last_word;
  logic                     word_done;
  logic [31:0]              word;
  logic [HDR_BYTES*8-1:0]   hdr_word;
  logic [CNT_W-1:0]         n_hdr;

  assign accept    = bus.s_valid && s_ready_q;
  assign start_ok  = start && (state_q inside {ST_IDLE, ST_DONE, ST_ERROR});
  assign hdr_word  = {bus.s_data, cnt_lo_q};
  assign n_hdr     = CNT_W'(hdr_word);
  assign last_word = (idx_q + 1'b1) == n_q;

  imem_word_assembler u_asm (
    .clk          (clk),
    .rst_n        (rst),
    .clear_i      (start_ok),
    .byte_valid_i (accept && (state_q == ST_DATA)),
    .byte_i       (bus.s_data),
    .word_done_o  (word_done),
    .word_o       (word)
  );

  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE, ST_DONE, ST_ERROR: if (start_ok) state_d = ST_CNT_LO;
      ST_CNT_LO: if (accept) state_d = ST_CNT_HI;
      ST_CNT_HI: begin
        if (accept) begin
          // Bounding N here is what keeps mem_addr from ever wrapping.
          if (n_hdr == '0)             state_d = ST_AFTER_DATA;
          else if (n_hdr > MAX_WORDS)  state_d = ST_ERROR;
          else                         state_d = ST_DATA;
        end
      end
      ST_DATA: if (word_done && last_word) state_d = ST_AFTER_DATA;
`ifdef IMEM_LOADER_CHECKSUM_EN
      ST_CHK: if (accept) state_d = (bus.s_data == xor_q) ? ST_DONE : ST_ERROR;
`endif
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q      <= ST_IDLE;
      cnt_lo_q     <= '0;
      n_q          <= '0;
      idx_q        <= '0;
      s_ready_q    <= 1'b0;
      mem_we_q     <= 1'b0;
      mem_addr_q   <= '0;
      mem_wdata_q  <= '0;
      core_rst_n_q <= 1'b0;
      busy_q       <= 1'b0;
      done_q       <= 1'b0;
      error_q      <= 1'b0;
`ifdef IMEM_LOADER_CHECKSUM_EN
      xor_q        <= '0;
`endif
    end else begin
      state_q      <= state_d;
      // Status outputs are decoded from the next state so they line up with state_q.
      s_ready_q    <= is_busy(state_d);
      busy_q       <= is_busy(state_d);
      done_q       <= (state_d == ST_DONE);
      error_q      <= (state_d == ST_ERROR);
      core_rst_n_q <= (state_d == ST_DONE);
      mem_we_q     <= word_done;
      if (word_done) begin
        mem_wdata_q <= word;
        mem_addr_q  <= idx_q[ADDR_W-1:0];
      end
      if (start_ok) begin
        n_q   <= '0;
        idx_q <= '0;
`ifdef IMEM_LOADER_CHECKSUM_EN
        xor_q <= '0;
`endif
      end else begin
        if (state_q == ST_CNT_LO && accept) cnt_lo_q <= bus.s_data;
        if (state_q == ST_CNT_HI && accept) n_q <= n_hdr;
        if (word_done) idx_q <= idx_q + 1'b1;
`ifdef IMEM_LOADER_CHECKSUM_EN
        if (state_q == ST_DATA && accept) xor_q <= xor_q ^ bus.s_data;
`endif
      end
    end
  end

  assign bus.s_ready   = s_ready_q;
  assign bus.mem_we    = mem_we_q;
  assign bus.mem_addr  = mem_addr_q;
  assign bus.mem_wdata = mem_wdata_q;
  assign core_rst_n    = core_rst_n_q;
  assign busy          = busy_q;
  assign done          = done_q;
  assign error         = error_q;
  assign dbg_state     = state_q;

endmodule

// File: tb/tb_imem_loader.sv
// Bench for imem_loader: table of image loads, corner sequences and random
// images checked against a stream-parsing reference model.
module tb_imem_loader;
  import imem_loader_pkg::*;

  localparam int ADDR_W = 6;
  localparam int CNT_W  = 16;
  localparam int CAP    = 1 << ADDR_W;
  localparam int W      = ADDR_W + 32;

  typedef struct {
    int          n;
    logic [31:0] w0;
    logic [31:0] w1;
    bit          bad_chk;
    int          gap;
    bit          exp_done;
    bit          exp_err;
  } vec_t;

  logic   clk = 1'b0;
  logic   rst;
  logic   start;
  logic   core_rst_n, busy, done, error;
  state_t dbg_state;

  int total = 0;
  int bad   = 0;
  int ready_low = 0;
  logic [W-1:0] exp_q[$];

  imem_loader_if #(.ADDR_W(ADDR_W)) bus ();

  imem_loader #(.ADDR_W(ADDR_W), .CNT_W(CNT_W)) dut (
    .clk        (clk),
    .rst        (rst),
    .start      (start),
    .bus        (bus),
    .core_rst_n (core_rst_n),
    .busy       (busy),
    .done       (done),
    .error      (error),
    .dbg_state  (dbg_state)
  );

  // ---------------- clock / watchdog ----------------
  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation still running at %0t, expected finish", $time);
    $fatal(1, "watchdog expired");
  end

  // ---------------- checks ----------------
  task automatic check_val(input string name, input logic [63:0] act, input logic [63:0] want);
    total++;
    if (act !== want) begin
      bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, want);
    end
  endtask

  task automatic check_bit(input string name, input logic act, input logic want);
    check_val(name, 64'(act), 64'(want));
  endtask

  task automatic check_idle_outputs(input string tag);
    check_bit({tag, "_s_ready"}, bus.s_ready, 1'b0);
    check_bit({tag, "_mem_we"}, bus.mem_we, 1'b0);
    check_val({tag, "_mem_addr"}, 64'(bus.mem_addr), 64'd0);
    check_val({tag, "_mem_wdata"}, 64'(bus.mem_wdata), 64'd0);
    check_bit({tag, "_core_rst_n"}, core_rst_n, 1'b0);
    check_bit({tag, "_busy"}, busy, 1'b0);
    check_bit({tag, "_done"}, done, 1'b0);
    check_bit({tag, "_error"}, error, 1'b0);
  endtask

  // Scoreboard: every write strobe must match the oldest expected {addr, data}.
  always @(negedge clk) begin
    if (bus.mem_we === 1'b1) begin
      if (exp_q.size() == 0) begin
        total++;
        bad++;
        $display("FAIL unexpected_write: got addr %0d data 0x%08h, expected no write",
                 bus.mem_addr, bus.mem_wdata);
      end else begin
        check_val("mem_write", 64'({bus.mem_addr, bus.mem_wdata}), 64'(exp_q.pop_front()));
      end
    end
  end

  // ---------------- stream build and reference model ----------------
  task automatic build_stream(input int n, input logic [31:0] words[$], input bit bad_chk,
                              output logic [7:0] st[$]);
    logic [7:0] b;
    logic [7:0] x;
    x = 8'h00;
    st.delete();
    st.push_back(8'(n));
    st.push_back(8'(n >> 8));
    if (n > CAP) return;
    for (int i = 0; i < n; i++) begin
      for (int k = 0; k < 4; k++) begin
        b = 8'(words[i] >> (8 * k));
        st.push_back(b);
        x = x ^ b;
      end
    end
`ifdef IMEM_LOADER_CHECKSUM_EN
    st.push_back(bad_chk ? (x ^ 8'h01) : x);
`else
    if (bad_chk && x == 8'h00) st.push_back(8'h00);
    if (bad_chk && x == 8'h00) void'(st.pop_back());
`endif
  endtask

  // Parses a stream as the image format defines it: count, then LE words.
  task automatic model(input logic [7:0] st[$], output bit m_done, output bit m_err);
    int n;
    logic [31:0] w;
    logic [7:0] x;
    n = int'(st[0]) + 256 * int'(st[1]);
    m_done = 1'b0;
    m_err  = 1'b0;
    if (n > CAP) begin
      m_err = 1'b1;
      return;
    end
    for (int i = 0; i < n; i++) begin
      w = 32'h0;
      for (int k = 0; k < 4; k++) w = w | (32'(st[2 + 4 * i + k]) << (8 * k));
      exp_q.push_back({ADDR_W'(i), w});
    end
    x = 8'h00;
`ifdef IMEM_LOADER_CHECKSUM_EN
    for (int j = 2; j < 2 + 4 * n; j++) x = x ^ st[j];
    if (st[2 + 4 * n] == x) m_done = 1'b1;
    else m_err = 1'b1;
`else
    m_done = (x == 8'h00);
`endif
  endtask

  // ---------------- drivers ----------------
  task automatic send_byte(input logic [7:0] b, input int max_gap, input bit poke, output bit ok);
    int gap;
    gap = int'($urandom_range(0, max_gap));
    ok = 1'b0;
    repeat (gap) begin
      bus.s_valid = 1'b0;
      bus.s_data  = 8'($urandom);
      if (bus.s_ready !== 1'b1) ready_low++;
      @(posedge clk); #1;
    end
    bus.s_valid = 1'b1;
    bus.s_data  = b;
    for (int c = 0; c < 20 && !ok; c++) begin
      if (bus.s_ready === 1'b1) ok = 1'b1;
      else ready_low++;
      // A start pulse while busy must be ignored.
      start = poke && ok && ($urandom_range(0, 3) == 0);
      @(posedge clk); #1;
      start = 1'b0;
    end
    bus.s_valid = 1'b0;
  endtask

  task automatic do_start(input string tag);
    bus.s_valid = 1'b0;
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    check_bit({tag, "_start_busy"}, busy, 1'b1);
    check_bit({tag, "_start_core_rst_n"}, core_rst_n, 1'b0);
    check_bit({tag, "_start_s_ready"}, bus.s_ready, 1'b1);
    check_bit({tag, "_start_done"}, done, 1'b0);
    check_bit({tag, "_start_error"}, error, 1'b0);
  endtask

  task automatic run_load(input string tag, input logic [7:0] st[$], input int max_gap,
                          input bit poke, input bit e_done, input bit e_err);
    bit ok;
    bit fin;
    fin = 1'b0;
    do_start(tag);
    ready_low = 0;
    for (int i = 0; i < st.size(); i++) begin
      send_byte(st[i], max_gap, poke && (i >= 2), ok);
      if (!ok) begin
        total++;
        bad++;
        $display("FAIL %s_accept: byte %0d not accepted within bound, expected acceptance", tag, i);
        break;
      end
    end
    for (int c = 0; c < 20; c++) begin
      if (done === 1'b1 || error === 1'b1) begin
        fin = 1'b1;
        break;
      end
      @(posedge clk); #1;
    end
    check_bit({tag, "_finished"}, fin, 1'b1);
    @(posedge clk); #1;
    check_bit({tag, "_done"}, done, e_done);
    check_bit({tag, "_error"}, error, e_err);
    check_bit({tag, "_core_rst_n"}, core_rst_n, e_done);
    check_bit({tag, "_s_ready"}, bus.s_ready, 1'b0);
    check_bit({tag, "_busy"}, busy, 1'b0);
    check_bit({tag, "_mem_we_idle"}, bus.mem_we, 1'b0);
    check_val({tag, "_writes_left"}, 64'(exp_q.size()), 64'd0);
    check_val({tag, "_ready_drops"}, 64'(ready_low), 64'd0);
    exp_q.delete();
  endtask

  function automatic vec_t mk(input int n, input logic [31:0] w0, input logic [31:0] w1,
                              input bit bad_chk, input int gap, input bit e_done, input bit e_err);
    vec_t v;
    v.n = n; v.w0 = w0; v.w1 = w1; v.bad_chk = bad_chk; v.gap = gap;
    v.exp_done = e_done; v.exp_err = e_err;
    return v;
  endfunction

  // ---------------- main sequence ----------------
  initial begin
    vec_t        vecs[$];
    logic [7:0]  st[$];
    logic [31:0] words[$];
    bit          m_done, m_err, ok;
    int          n;

    rst = 1'b1;
    start = 1'b0;
    bus.s_valid = 1'b0;
    bus.s_data  = 8'h00;
    #1 rst = 1'b0;
    #2;
    check_idle_outputs("reset");
    check_val("reset_state", 64'(dbg_state), 64'(ST_IDLE));
    repeat (2) @(posedge clk);
    #1 rst = 1'b1;

    // Stream activity in IDLE without start is neither consumed nor acted on.
    bus.s_valid = 1'b1;
    bus.s_data  = 8'h55;
    repeat (3) @(posedge clk);
    #1;
    check_idle_outputs("idle_valid");
    bus.s_valid = 1'b0;

    vecs.push_back(mk(2,       32'h00000013, 32'h00100093, 1'b0, 0, 1'b1, 1'b0));
    vecs.push_back(mk(1,       32'h08040201, 32'h0,        1'b0, 3, 1'b1, 1'b0));
    vecs.push_back(mk(65,      32'h0,        32'h0,        1'b0, 0, 1'b0, 1'b1));
    vecs.push_back(mk(0,       32'h0,        32'h0,        1'b0, 0, 1'b1, 1'b0));
    vecs.push_back(mk(64,      32'hDEADBEEF, 32'h12345678, 1'b0, 1, 1'b1, 1'b0));
    vecs.push_back(mk(16'hFFFF, 32'h0,       32'h0,        1'b0, 0, 1'b0, 1'b1));
    vecs.push_back(mk(1,       32'hCAFEF00D, 32'h0,        1'b0, 0, 1'b1, 1'b0));
`ifdef IMEM_LOADER_CHECKSUM_EN
    vecs.push_back(mk(1,       32'h08040201, 32'h0,        1'b0, 0, 1'b1, 1'b0));
    vecs.push_back(mk(1,       32'h08040201, 32'h0,        1'b1, 0, 1'b0, 1'b1));
`endif

    for (int i = 0; i < vecs.size(); i++) begin
      words.delete();
      for (int j = 0; j < vecs[i].n && j < CAP; j++)
        words.push_back(j == 0 ? vecs[i].w0 : (j == 1 ? vecs[i].w1 : $urandom));
      build_stream(vecs[i].n, words, vecs[i].bad_chk, st);
      model(st, m_done, m_err);
      run_load($sformatf("vec%0d", i), st, vecs[i].gap, 1'b0, vecs[i].exp_done, vecs[i].exp_err);
    end

    // Reset after five payload bytes: one word already written, then abort.
    words.delete();
    words.push_back(32'h11223344);
    words.push_back(32'h55667788);
    build_stream(2, words, 1'b0, st);
    model(st, m_done, m_err);
    do_start("mid");
    for (int i = 0; i < 7; i++) begin
      send_byte(st[i], 0, 1'b0, ok);
      check_bit($sformatf("mid_accept%0d", i), ok, 1'b1);
    end
    #2 rst = 1'b0;
    #1;
    check_idle_outputs("mid_rst");
    check_val("mid_pending_writes", 64'(exp_q.size()), 64'd1);
    exp_q.delete();
    @(posedge clk);
    #1 rst = 1'b1;
    @(posedge clk); #1;
    words.delete();
    words.push_back(32'hA5A5_0F0F);
    words.push_back(32'h0000_0001);
    build_stream(2, words, 1'b0, st);
    model(st, m_done, m_err);
    run_load("after_rst", st, 1, 1'b0, 1'b1, 1'b0);

    // Random images, gaps and ignored start pulses.
    for (int r = 0; r < 10; r++) begin
      if ($urandom_range(0, 3) == 0) n = int'($urandom_range(CAP - 3, CAP + 3));
      else n = int'($urandom_range(0, 8));
      words.delete();
      for (int j = 0; j < n && j < CAP; j++) words.push_back($urandom);
      build_stream(n, words, ($urandom_range(0, 3) == 0), st);
      model(st, m_done, m_err);
      run_load($sformatf("rnd%0d", r), st, 2, 1'b1, m_done, m_err);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
